// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Bits are sampled at mid-period, timed from the start-bit falling edge.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX_in,
  input  logic       enable_parity,
  output logic [7:0] rx_data_8bit,
  output logic       valid_out,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sync;
  logic [1:0]       r_sync_live;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_par_en;
  logic             r_par_bit;

  logic w_rx_s;
  logic w_bit_end;
  logic w_par_err;

  assign w_rx_s    = r_sync[1];
  assign w_bit_end = (r_cnt == FULL_LAST);
  assign w_par_err = r_par_en & (^r_shift ^ r_par_bit);

  // Two-flop synchronizer; r_sync_live marks when rx_s reflects the line rather than reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync      <= 2'b11;
      r_sync_live <= 2'b00;
    end else begin
      r_sync      <= {r_sync[0], RX_in};
      r_sync_live <= {r_sync_live[0], 1'b1};
    end
  end

  // Receive FSM; r_armed requires a genuine high line before a falling edge counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_armed       <= 1'b0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      r_par_en      <= 1'b0;
      r_par_bit     <= 1'b0;
      rx_data_8bit  <= '0;
      valid_out     <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_sync_live[1] && w_rx_s) begin
            r_armed <= 1'b1;
          end
          if (r_armed && !w_rx_s) begin
            r_state  <= S_START;
            r_cnt    <= '0;
            r_par_en <= enable_parity;
            r_armed  <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_shift[r_idx] <= w_rx_s;
            r_cnt          <= '0;
            if (r_idx == 3'd7) begin
              r_idx   <= '0;
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_par_bit <= w_rx_s;
            r_cnt     <= '0;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_cnt         <= '0;
            r_state       <= S_IDLE;
            busy          <= 1'b0;
            valid_out     <= 1'b1;
            rx_data_8bit  <= r_shift;
            framing_error <= ~w_rx_s;
            parity_error  <= w_par_err;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and randomized frames against a byte-level model.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RX_in = 1'b1;
  logic       enable_parity = 1'b0;
  logic [7:0] rx_data_8bit;
  logic       valid_out;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .RX_in         (RX_in),
    .enable_parity (enable_parity),
    .rx_data_8bit  (rx_data_8bit),
    .valid_out     (valid_out),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hold_viol = 0;
  int   last_valid_cyc = 0;
  int   send_cyc = 0;
  bit   busy_seen = 1'b0;
  bit   prev_ok = 1'b0;
  logic [9:0] prev_out;

  always @(posedge clk) cyc++;

  // Collect pulses and watch that outputs only move with valid_out.
  always @(negedge clk) begin
    if (!reset) begin
      prev_ok = 1'b0;
    end else begin
      if (valid_out) begin
        got_q.push_back('{data: rx_data_8bit, perr: parity_error, ferr: framing_error});
        last_valid_cyc = cyc;
      end else if (prev_ok && ({rx_data_8bit, parity_error, framing_error} !== prev_out)) begin
        hold_viol++;
      end
      prev_out = {rx_data_8bit, parity_error, framing_error};
      prev_ok  = 1'b1;
    end
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_bits(input int unsigned n);
    repeat (n * CPB) @(negedge clk);
  endtask

  // Drives one frame on the line and records what the receiver should report.
  task automatic send(input logic [7:0] d, input bit pen, input bit pbit,
                      input bit stopb, input bit toggle_en);
    rec_t r;
    enable_parity = pen;
    send_cyc = cyc;
    RX_in = 1'b0;
    hold_bits(1);
    if (toggle_en) enable_parity = ~pen;
    for (int i = 0; i < 8; i++) begin
      RX_in = d[i];
      hold_bits(1);
    end
    if (pen) begin
      RX_in = pbit;
      hold_bits(1);
    end
    RX_in = stopb;
    hold_bits(1);
    r.data = d;
    r.perr = pen && ((($countones(d) + int'(pbit)) % 2) != 0);
    r.ferr = !stopb;
    exp_q.push_back(r);
  endtask

  task automatic drain(input string tag);
    rec_t e, g;
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    hold_bits(2);
    check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, " data"}, 32'(g.data), 32'(e.data));
      check({tag, " parity_error"}, 32'(g.perr), 32'(e.perr));
      check({tag, " framing_error"}, 32'(g.ferr), 32'(e.ferr));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    int lat;

    repeat (3) @(negedge clk);
    check("reset data", 32'(rx_data_8bit), 32'h0);
    check("reset valid", 32'(valid_out), 32'h0);
    check("reset perr", 32'(parity_error), 32'h0);
    check("reset ferr", 32'(framing_error), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    reset = 1'b1;
    hold_bits(4);

    send(8'h62, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("byte62");
    lat = last_valid_cyc - send_cyc;
    check("byte62 latency in window", 32'(lat >= 152 && lat <= 172), 32'h1);
    check("byte62 busy after", 32'(busy), 32'h0);

    send(8'hCC, 1'b1, 1'b0, 1'b1, 1'b0);
    send(8'hCC, 1'b1, 1'b1, 1'b1, 1'b0);
    drain("parityCC");

    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_bits(40);
    drain("framingA5");
    check("held low busy", 32'(busy), 32'h0);
    RX_in = 1'b1;
    hold_bits(2);

    busy_seen = 1'b0;
    RX_in = 1'b0;
    repeat (3) @(negedge clk);
    RX_in = 1'b1;
    hold_bits(2);
    check("glitch busy pulsed", 32'(busy_seen), 32'h1);
    check("glitch busy idle", 32'(busy), 32'h0);
    check("glitch no valid", 32'(got_q.size()), 32'h0);
    check("glitch data held", 32'(rx_data_8bit), 32'hA5);
    check("glitch ferr held", 32'(framing_error), 32'h1);

    send(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("b2b");

    for (int k = 0; k < 16; k++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      hold_bits($urandom_range(0, 2));
    end
    drain("random");

    d = 8'h5A;
    enable_parity = 1'b0;
    RX_in = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 4; i++) begin
      RX_in = d[i];
      hold_bits(1);
    end
    RX_in = d[4];
    repeat (CPB / 2) @(negedge clk);
    RX_in = 1'b0;
    reset = 1'b0;
    #1;
    check("midreset data", 32'(rx_data_8bit), 32'h0);
    check("midreset valid", 32'(valid_out), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    check("midreset flags", 32'({parity_error, framing_error}), 32'h0);
    repeat (4) @(negedge clk);
    busy_seen = 1'b0;
    reset = 1'b1;
    hold_bits(3);
    check("low at release no start", 32'(busy_seen), 32'h0);
    check("midreset no valid", 32'(got_q.size()), 32'h0);
    RX_in = 1'b1;
    hold_bits(2);
    send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("after reset 3C");

    check("outputs held between pulses", 32'(hold_viol), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 CLKS_PER_BIT, default 16: clk cycles per serial bit period; legal values are even integers of 4 or more.
REQ-002 clk  input  1  rising-edge system clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 RX_in  input  1  serial line; idles high; asynchronous to clk.
REQ-005 enable_parity  input  1  1 = frame carries an even-parity bit after data bit 7.
REQ-006 rx_data_8bit  output  8  last received byte, LSB first on the line.
REQ-007 valid_out  output  1  one-cycle pulse when a frame completes.
REQ-008 parity_error  output  1  parity status of the last frame.
REQ-009 framing_error  output  1  stop-bit status of the last frame.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 RX_in SHALL pass through a 2-flop synchronizer (rx_s) before any other use; the synchronizer flops reset to 1.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with a bit-period counter cnt and a bit index idx (0-7).
REQ-013 IDLE: a falling edge on rx_s (previous 1, current 0) SHALL move the FSM to START, clear cnt and latch enable_parity into par_en.
REQ-014 START: at cnt = CLKS_PER_BIT/2-1, if rx_s = 0, the FSM SHALL clear cnt and go to DATA with idx = 0; if rx_s = 1, it SHALL treat the edge as a glitch and return to IDLE with no valid_out.
REQ-015 DATA: at cnt = CLKS_PER_BIT-1, the FSM SHALL sample rx_s into shift bit idx and clear cnt; after idx = 7 it SHALL go to PARITY if par_en = 1, else to STOP.
REQ-016 PARITY: at cnt = CLKS_PER_BIT-1, the FSM SHALL sample the parity bit and go to STOP; the computed error is XOR of the 8 data bits and the parity bit.
REQ-017 STOP: at cnt = CLKS_PER_BIT-1, the FSM SHALL sample the stop bit and return to IDLE.
- In the next cycle: rx_data_8bit <= shifted byte, framing_error <= (stop bit = 0), parity_error <= par_en & computed error, valid_out = 1 for exactly one cycle.
REQ-018 The block SHALL deliver the byte and pulse valid_out even when framing_error or parity_error is set.
REQ-019 rx_data_8bit, parity_error and framing_error SHALL hold their values until the next valid_out.
REQ-020 When par_en = 0, parity_error SHALL be 0.
REQ-021 After a framing error (line still low), IDLE SHALL require rx_s to return to 1 before a new falling edge is accepted; a held-low line SHALL produce no further frames.
REQ-022 enable_parity changes during a frame SHALL have no effect until the next start detection.
REQ-023 A frame with no parity SHALL complete 10 bit periods after the start-bit falling edge at rx_s, to within half a bit period.
- Total latency from the RX_in edge adds 2 synchronizer cycles.

Reset
REQ-024 While reset = 0, the block SHALL asynchronously force: FSM = IDLE, cnt = 0, idx = 0, shift register = 0, rx_data_8bit = 0x00, valid_out = 0, parity_error = 0, framing_error = 0, busy = 0, synchronizer = 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no valid_out.
- After release, a line low at release SHALL NOT start a frame until it goes high and then falls.

Verification
REQ-026 CLKS_PER_BIT = 16, parity off, serial frame 0x62 -> exactly one valid_out pulse; rx_data_8bit = 0x62; both error flags 0; busy low afterwards.
REQ-027 Parity on, byte 0xCC with parity bit 0 -> rx_data_8bit = 0xCC, parity_error = 0.
- Same frame with parity bit 1 -> rx_data_8bit = 0xCC, parity_error = 1.
REQ-028 Byte 0xA5 with stop bit driven 0 -> valid_out pulses, rx_data_8bit = 0xA5, framing_error = 1.
- Line then held low for 40 bit periods -> no further valid_out.
REQ-029 Low glitch of 3 clk cycles on an idle line -> busy pulses, FSM returns to IDLE, no valid_out, outputs unchanged.
REQ-030 reset asserted at data bit 4 of a frame -> all outputs 0 immediately, no valid_out.
- After release, a following frame 0x3C -> rx_data_8bit = 0x3C.
REQ-031 Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three valid_out pulses carrying 0x00, 0xFF and 0x81 in order.
